// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// The grant, tx and busy outputs are all registered; an asynchronous reset aborts any frame in progress.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [1:0]  cur_id,
  output logic        busy,
  output logic        tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [1:0]  r_last;
  logic [3:0]  r_grant;
  logic [1:0]  r_cur;
  logic        r_busy;
  logic        r_tx;

  logic [1:0]  w_sel;
  logic [1:0]  w_cand;
  logic        w_any;
  logic        w_bit_end;

  // Walk offsets 4 down to 1 so that the smallest offset after r_last wins.
  always_comb begin
    w_any  = |req;
    w_sel  = r_last;
    w_cand = r_last;
    for (int unsigned k = 4; k > 0; k--) begin
      w_cand = r_last + 2'(k);
      if (req[w_cand]) w_sel = w_cand;
    end
    w_bit_end = (r_cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_last  <= 2'd3;
      r_grant <= '0;
      r_cur   <= '0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_grant <= '0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_any) begin
            r_shift <= req_data[{w_sel, 3'b000} +: 8];
            r_cur   <= w_sel;
            r_last  <= w_sel;
            r_grant <= 4'b0001 << w_sel;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // r_shift[0] is always the bit currently on the line.
        DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant  = r_grant;
  assign cur_id = r_cur;
  assign busy   = r_busy;
  assign tx     = r_tx;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at CLKS_PER_BIT=4: directed scenarios plus a randomized run
// checked against a frame-level round-robin model and a loopback UART receiver.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  cur_id;
  logic        busy;
  logic        tx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .cur_id(cur_id), .busy(busy), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Loopback receiver: samples mid-bit, counted in clock edges from the start edge.
  logic [7:0] rx_q[$];
  int         start_t[$];
  int         rx_ferr = 0;
  int         rx_cnt  = -1;
  logic [7:0] rx_sh   = '0;

  initial forever begin
    @(posedge clk); #1;
    if (rst) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (tx === 1'b0) begin
        rx_cnt = 0;
        start_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 && rx_cnt < 9*CPB && (rx_cnt - CPB/2) % CPB == 0)
        rx_sh = {tx, rx_sh[7:1]};
      if (rx_cnt == 9*CPB + CPB/2) begin
        rx_q.push_back(rx_sh);
        if (tx !== 1'b1) rx_ferr++;
        rx_cnt = -1;
      end
    end
  end

  // Frame-level reference: free/occupied for 10*CPB edges, round-robin pick on free.
  logic [7:0] exp_q[$];
  bit         m_free;
  int         m_remain;
  int         m_last;
  int         m_cur;
  logic [3:0] m_grant;

  task automatic model_init();
    m_free = 1; m_remain = 0; m_last = 3; m_cur = 0; m_grant = '0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [31:0] d);
    int pick;
    pick = -1;
    m_grant = '0;
    if (m_free && r != 0) begin
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
      m_grant = 4'(1 << pick);
      m_free = 0;
      m_remain = 10*CPB;
      m_last = pick;
      m_cur = pick;
      exp_q.push_back(d[8*pick +: 8]);
    end else if (!m_free) begin
      m_remain--;
      if (m_remain == 0) m_free = 1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  // Holds reset over a few edges and releases it 1 time unit after an edge with req/req_data as set.
  task automatic apply_reset(input logic [3:0] r, input logic [31:0] d);
    rst = 1'b1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    rx_q.delete(); start_t.delete(); rx_ferr = 0;
    req = r; req_data = d;
    rst = 1'b0;
  endtask

  task automatic test_reset_and_single();
    logic [7:0] b;
    logic       e;
    b = 8'h55;
    rst = 1'b1; req = '0; req_data = '0;
    @(posedge clk); #1;
    total++; if (tx !== 1'b1)     begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (grant !== 4'b0)  begin bad++; $display("FAIL rst_grant got=%b exp=0000", grant); end
    total++; if (cur_id !== 2'd0) begin bad++; $display("FAIL rst_cur_id got=%0d exp=0", cur_id); end
    req = 4'b0001; req_data = {24'h0, b};
    rst = 1'b0;
    @(posedge clk); #1;
    req = '0;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
    total++; if (tx !== 1'b0)       begin bad++; $display("FAIL single_start got=%b exp=0", tx); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (cur_id !== 2'd0)   begin bad++; $display("FAIL single_cur_id got=%0d exp=0", cur_id); end
    for (int k = 1; k < 10*CPB; k++) begin
      @(posedge clk); #1;
      e = frame_bit(b, k / CPB);
      total++; if (tx !== e)        begin bad++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, tx, e); end
      total++; if (busy !== 1'b1)   begin bad++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy); end
      total++; if (grant !== 4'b0)  begin bad++; $display("FAIL single_grant_pulse k=%0d got=%b exp=0000", k, grant); end
    end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
  endtask

  task automatic test_rotation();
    logic [3:0] g[$];
    int         t[$];
    logic [7:0] eb;
    logic [3:0] eg;
    apply_reset(4'b1111, 32'h43322110);
    for (int n = 0; n < 260 && g.size() < 5; n++) begin
      @(posedge clk); #1;
      if (grant != 0) begin g.push_back(grant); t.push_back(cyc); end
    end
    total++; if (g.size() != 5) begin bad++; $display("FAIL rot_count got=%0d exp=5", g.size()); end
    for (int i = 0; i < g.size(); i++) begin
      eg = 4'(1 << (i % 4));
      total++; if (g[i] !== eg) begin bad++; $display("FAIL rot_grant i=%0d got=%b exp=%b", i, g[i], eg); end
      if (i > 0) begin
        total++; if (t[i] - t[i-1] != 10*CPB + 1)
          begin bad++; $display("FAIL rot_spacing i=%0d got=%0d exp=%0d", i, t[i]-t[i-1], 10*CPB+1); end
      end
    end
    total++; if (rx_q.size() < 4) begin bad++; $display("FAIL rot_rx_count got=%0d exp>=4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      eb = 8'(8'h10 + 8'h11 * i);
      total++; if (rx_q[i] !== eb) begin bad++; $display("FAIL rot_byte i=%0d got=%h exp=%h", i, rx_q[i], eb); end
    end
    total++; if (rx_ferr != 0) begin bad++; $display("FAIL rot_stop_bit got=%0d exp=0", rx_ferr); end
  endtask

  task automatic test_late_request();
    logic [3:0] g[$];
    int         t[$];
    logic       prev_busy;
    apply_reset(4'b0100, 32'h00AA0000);
    for (int n = 0; n < 200 && g.size() < 3; n++) begin
      prev_busy = busy;
      if (n == 20) begin req = 4'b0110; req_data = 32'h00AA5C00; end
      @(posedge clk); #1;
      if (grant != 0) begin
        total++; if (prev_busy !== 1'b0) begin bad++; $display("FAIL late_grant_busy n=%0d got=%b exp=0", n, prev_busy); end
        g.push_back(grant); t.push_back(cyc);
      end
    end
    total++; if (g.size() != 3) begin bad++; $display("FAIL late_count got=%0d exp=3", g.size()); end
    if (g.size() == 3) begin
      total++; if (g[0] !== 4'b0100) begin bad++; $display("FAIL late_g0 got=%b exp=0100", g[0]); end
      total++; if (g[1] !== 4'b0010) begin bad++; $display("FAIL late_g1 got=%b exp=0010", g[1]); end
      total++; if (g[2] !== 4'b0100) begin bad++; $display("FAIL late_g2 got=%b exp=0100", g[2]); end
      total++; if (t[1] - t[0] != 10*CPB + 1) begin bad++; $display("FAIL late_spacing got=%0d exp=%0d", t[1]-t[0], 10*CPB+1); end
    end
    total++; if (rx_q.size() < 2 || rx_q[1] !== 8'h5C)
      begin bad++; $display("FAIL late_byte got_n=%0d exp=5c", rx_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset(4'b0001, 32'h0);
    @(posedge clk); #1;
    req = '0;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_grant got=%b exp=0001", grant); end
    repeat (15) @(posedge clk);
    #1;
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx got=%b exp=0", tx); end
    #1 rst = 1'b1;
    #1;
    total++; if (tx !== 1'b1)   begin bad++; $display("FAIL mid_abort_tx got=%b exp=1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_abort_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      total++; if (tx !== 1'b1 || busy !== 1'b0 || grant !== 4'b0)
        begin bad++; $display("FAIL mid_idle k=%0d tx=%b busy=%b grant=%b exp=1/0/0000", k, tx, busy, grant); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  r, rs;
    logic [31:0] ds;
    logic [7:0]  bytes [4];
    int          waits [4];
    int          max_wait;
    int          gi;
    r = '0; max_wait = 0;
    for (int i = 0; i < 4; i++) begin bytes[i] = '0; waits[i] = 0; end
    apply_reset(4'b0, 32'h0);
    model_init();
    for (int n = 0; n < 10000 + 50; n++) begin
      if (n >= 10000) r = '0;
      req = r;
      req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
      rs = req; ds = req_data;
      @(posedge clk); #1;
      model_edge(rs, ds);
      total++; if (grant !== m_grant) begin bad++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, grant, m_grant); end
      total++; if (busy !== !m_free)  begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, !m_free); end
      total++; if (cur_id !== 2'(m_cur)) begin bad++; $display("FAIL rnd_cur_id n=%0d got=%0d exp=%0d", n, cur_id, m_cur); end
      total++; if (!$onehot0(grant)) begin bad++; $display("FAIL rnd_onehot n=%0d got=%b exp=onehot0", n, grant); end
      if (grant != 0) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
        for (int i = 0; i < 4; i++) begin
          if (i == gi) waits[i] = 0;
          else if (rs[i]) begin waits[i]++; if (waits[i] > max_wait) max_wait = waits[i]; end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (m_grant[i]) begin
          r[i] = 1'($urandom_range(0, 1));
          bytes[i] = 8'($urandom);
        end else if (!r[i] && $urandom_range(0, 7) == 0) begin
          r[i] = 1'b1;
          bytes[i] = 8'($urandom);
        end
      end
    end
    total++; if (rx_q.size() != exp_q.size())
      begin bad++; $display("FAIL rnd_frames got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_byte i=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (rx_ferr != 0)  begin bad++; $display("FAIL rnd_stop_bit got=%0d exp=0", rx_ferr); end
    total++; if (max_wait > 4)  begin bad++; $display("FAIL rnd_starve got=%0d exp<=4", max_wait); end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    #2;
    test_reset_and_single();
    test_rotation();
    test_late_request();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (9600 baud at 50 MHz); legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port req  input  4  per-requester transmit request; bit i is requester i.
REQ-005 Port req_data  input  32  per-requester byte; requester i at bits [8i+7:8i].
REQ-006 Port grant  output  4  one-hot, one-cycle pulse: byte of requester i captured.
REQ-007 Port cur_id  output  2  index of the requester owning the current or last frame.
REQ-008 Port busy  output  1  high while a frame is being serialized.
REQ-009 Port tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-010 The block SHALL share one 8N1 transmitter among 4 requesters using round-robin arbitration.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP; no other states are reachable.
REQ-012 In IDLE with req != 0, the block SHALL select the first requesting index searching upward from (last_grant+1) mod 4.
REQ-013 On selection, the block SHALL, at the next edge:
  - latch that requester's byte
  - set cur_id
  - pulse grant[i] high for exactly one cycle
  - drive tx low
  - assert busy
  - enter START
REQ-014 Latency from req sampled high in IDLE to grant pulse and tx falling SHALL be exactly 1 clock.
REQ-015 A requester SHALL hold req and req_data stable until its grant; after grant it MAY present a new byte or drop req.
REQ-016 req changes during START/DATA/STOP SHALL NOT affect the frame in progress.
REQ-017 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and SHALL NOT wrap past CLKS_PER_BIT-1.
REQ-018 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-019 DATA SHALL drive bits 0..7 of the latched byte, each for CLKS_PER_BIT cycles, then enter STOP.
REQ-020 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then enter IDLE with busy deasserted.
REQ-021 A frame SHALL last exactly 10*CLKS_PER_BIT cycles from tx falling to busy falling.
REQ-022 IDLE SHALL last at least one cycle, so the minimum spacing between consecutive start-bit edges is 10*CLKS_PER_BIT+1 cycles.
REQ-023 last_grant SHALL update only when a grant is issued.
REQ-024 A single continuously requesting requester SHALL be granted every frame.
REQ-025 With all four requesting continuously, grant order SHALL rotate 0,1,2,3,0...
REQ-026 grant SHALL be 0 in every cycle except a grant cycle and SHALL never have more than one bit set.
REQ-027 tx, busy and grant SHALL be driven directly from registers (no combinational path from req).

Reset
REQ-028 While rst is high:
  - tx=1, busy=0, grant=0, cur_id=0
  - state=IDLE
  - bit counter and bit index = 0
  - last_grant=3 (requester 0 has highest priority after reset)
REQ-029 Assertion of rst mid-frame SHALL abort the frame immediately (asynchronously) with tx=1; no frame resumes after release.
REQ-030 The first edge after rst deasserts SHALL be able to perform arbitration if req != 0.

Verification
REQ-031 CLKS_PER_BIT=4, req=0001, byte0=0x55 -> grant=0001 one cycle later; tx line = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high for 40 cycles.
REQ-032 CLKS_PER_BIT=4, req=1111 held, bytes 0x10,0x21,0x32,0x43 -> grants 0001,0010,0100,1000,0001; decoded bytes in that order; start edges 41 cycles apart.
REQ-033 req=0100 held, req[1] raised mid-frame -> next grant 0010, then 0100; no grant while busy.
REQ-034 rst asserted at cycle 15 of a frame -> tx=1 and busy=0 in the same cycle; after release with req=0 the line stays idle-high.
REQ-035 Default CLKS_PER_BIT=5208, sequence of 8 bytes 0x00..0x07 from requester 3 -> a loopback receiver decodes all 8 bytes intact; each frame is 52080 cycles.
REQ-036 Random req/req_data for 10^4 cycles -> grant always one-hot or zero; every granted byte appears on tx exactly once; no requester starves for more than 4 frames.
